// File: rtl/delay_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// delay_mem_pkg
//   Shared types and constants for the delay-line memory responder.
//   - delay_mem_state_e : responder FSM state encoding
//   - DELAY_MEM_READ_LATENCY : edges from read accept to read-data-valid
//   - addr_out_of_range : address bound check against the RAM depth
//   Optional macro: DELAY_MEM_CLEAR_EN adds the CLEAR (initial sweep) state.
// ---------------------------------------------------------------------------
package delay_mem_pkg;

`ifdef DELAY_MEM_CLEAR_EN
   typedef enum logic [2:0] {
      IDLE,
      WRITE,
      READ_ADDR,
      READ_DATA,
      CLEAR
   } delay_mem_state_e;
`else
   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ_ADDR,
      READ_DATA
   } delay_mem_state_e;
`endif

   localparam int unsigned DELAY_MEM_READ_LATENCY = 2;

   function automatic logic addr_out_of_range(input int unsigned addr,
                                              input int unsigned size);
      return addr >= size;
   endfunction

endpackage

// File: rtl/delay_mem_responder_if.sv
// ---------------------------------------------------------------------------
// delay_mem_responder_if
//   Request/response bundle between the delay buffer manager (master) and
//   the memory responder (slave).
//   master drives : mem_write_req, mem_write_addr, mem_data_out,
//                   mem_read_req, mem_read_addr
//   slave drives  : mem_write_ack, mem_read_valid, mem_data_in, addr_error
// ---------------------------------------------------------------------------
interface delay_mem_responder_if #(
   parameter int unsigned data_width = 16,
   parameter int unsigned addr_width = 13
);
   logic                         mem_write_req;
   logic [addr_width-1:0]        mem_write_addr;
   logic signed [data_width-1:0] mem_data_out;
   logic                         mem_write_ack;
   logic                         mem_read_req;
   logic [addr_width-1:0]        mem_read_addr;
   logic signed [data_width-1:0] mem_data_in;
   logic                         mem_read_valid;
   logic                         addr_error;

   modport master (
      output mem_write_req, mem_write_addr, mem_data_out,
             mem_read_req, mem_read_addr,
      input  mem_write_ack, mem_read_valid, mem_data_in, addr_error
   );

   modport slave (
      input  mem_write_req, mem_write_addr, mem_data_out,
             mem_read_req, mem_read_addr,
      output mem_write_ack, mem_read_valid, mem_data_in, addr_error
   );
endinterface

// File: rtl/delay_mem_responder_ram.sv
// ---------------------------------------------------------------------------
// delay_mem_ram
//   Single-port synchronous sample RAM, memory_size x data_width.
//   Ports: clk, we (write enable), addr, wdata, rdata (registered read of
//   addr, updated every edge). The array has no reset.
// ---------------------------------------------------------------------------
module delay_mem_ram #(
   parameter int unsigned data_width  = 16,
   parameter int unsigned memory_size = 8192,
   parameter int unsigned addr_width  = $clog2(memory_size)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [addr_width-1:0] addr,
   input  logic [data_width-1:0] wdata,
   output logic [data_width-1:0] rdata
);
   logic [data_width-1:0] mem [memory_size];

   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
   end
endmodule

// File: rtl/delay_mem_responder.sv
// ---------------------------------------------------------------------------
// delay_mem_responder
//   Memory-side responder for the delay-line memory port. Serialises the
//   level-held read/write requests onto an internal single-port RAM and
//   returns one-cycle mem_write_ack / mem_read_valid pulses. Writes win over
//   simultaneous reads; out-of-range addresses pulse addr_error.
//   Ports:
//     clk        : clock
//     reset_n    : asynchronous active-low reset
//     bus        : delay_mem_responder_if.slave (requests in, ack/data out)
//     clear_busy : initial zero-fill sweep in progress (0 when not built in)
//   Optional macro: DELAY_MEM_CLEAR_EN enables the post-reset clear sweep.
// ---------------------------------------------------------------------------
module delay_mem_responder
   import delay_mem_pkg::*;
#(
   parameter int unsigned data_width  = 16,
   parameter int unsigned memory_size = 8192,
   parameter int unsigned addr_width  = $clog2(memory_size)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   delay_mem_responder_if.slave bus,
   output logic                 clear_busy
);

`ifdef DELAY_MEM_CLEAR_EN
   localparam delay_mem_state_e RESET_STATE = CLEAR;
`else
   localparam delay_mem_state_e RESET_STATE = IDLE;
`endif

   delay_mem_state_e      state_q, state_d;
   logic                  wr_pend, rd_pend;
   logic                  wr_accept, rd_accept, rd_finish;
   logic                  wr_oob, rd_oob, rd_oob_q;
   logic                  ack_q, valid_q, err_q;
   logic [data_width-1:0] data_in_q;
   logic                  ram_we_q;
   logic [addr_width-1:0] ram_addr_q;
   logic [data_width-1:0] ram_wdata_q;
   logic                  ram_we;
   logic [addr_width-1:0] ram_addr;
   logic [data_width-1:0] ram_wdata, ram_rdata;
   logic                  clr_last;

   assign wr_oob = addr_out_of_range(32'(bus.mem_write_addr), memory_size);
   assign rd_oob = addr_out_of_range(32'(bus.mem_read_addr), memory_size);

   // A request still held high while its own ack/valid is showing has already
   // been served; ignore it for that cycle.
   assign wr_pend = bus.mem_write_req && !ack_q;
   assign rd_pend = bus.mem_read_req  && !valid_q;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= RESET_STATE;
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (wr_pend)      state_d = WRITE;
            else if (rd_pend) state_d = READ_ADDR;
         end
         WRITE:     state_d = IDLE;
         READ_ADDR: state_d = READ_DATA;
         READ_DATA: state_d = IDLE;
`ifdef DELAY_MEM_CLEAR_EN
         CLEAR:     if (clr_last) state_d = IDLE;
`endif
         default:   state_d = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      wr_accept = (state_q == IDLE) && wr_pend;
      rd_accept = (state_q == IDLE) && rd_pend && !wr_pend;
      rd_finish = (state_q == READ_DATA);
   end

   // Registered responses and RAM port; reset clears ram_we_q so a write
   // not yet at its commit edge is dropped.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ack_q       <= 1'b0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
         data_in_q   <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         rd_oob_q    <= 1'b0;
      end else begin
         ack_q    <= wr_accept;
         valid_q  <= rd_finish;
         err_q    <= (wr_accept && wr_oob) || (rd_finish && rd_oob_q);
         ram_we_q <= wr_accept && !wr_oob;
         if (wr_accept) begin
            ram_addr_q  <= wr_oob ? '0 : bus.mem_write_addr;
            ram_wdata_q <= bus.mem_data_out;
         end else if (rd_accept) begin
            ram_addr_q <= rd_oob ? '0 : bus.mem_read_addr;
            rd_oob_q   <= rd_oob;
         end
         if (rd_finish) data_in_q <= rd_oob_q ? '0 : ram_rdata;
      end
   end

`ifdef DELAY_MEM_CLEAR_EN
   logic                  clearing;
   logic [addr_width-1:0] clr_addr_q;

   assign clearing = (state_q == CLEAR);
   assign clr_last = (clr_addr_q == addr_width'(memory_size - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      clr_addr_q <= '0;
      else if (clearing) clr_addr_q <= clr_addr_q + addr_width'(1);
   end

   // The sweep owns the RAM port until it reaches the last word.
   assign ram_we     = clearing | ram_we_q;
   assign ram_addr   = clearing ? clr_addr_q : ram_addr_q;
   assign ram_wdata  = clearing ? '0 : ram_wdata_q;
   assign clear_busy = clearing;
`else
   assign clr_last   = 1'b0;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign clear_busy = 1'b0;
`endif

   delay_mem_ram #(
      .data_width  (data_width),
      .memory_size (memory_size),
      .addr_width  (addr_width)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign bus.mem_write_ack  = ack_q;
   assign bus.mem_read_valid = valid_q;
   assign bus.addr_error     = err_q;
   assign bus.mem_data_in    = data_in_q;

endmodule

// File: tb/tb_delay_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_delay_mem_responder
//   Randomised bench for delay_mem_responder (memory_size = 6000) with a
//   transaction-level reference: an array of stored words plus fixed
//   response latencies. Inputs change and outputs are sampled on negedges.
//   Builds with or without DELAY_MEM_CLEAR_EN.
// ---------------------------------------------------------------------------
module tb_delay_mem_responder;
   import delay_mem_pkg::*;

   localparam int unsigned DW = 16;
   localparam int unsigned MS = 6000;
   localparam int unsigned AW = $clog2(MS);
   localparam int unsigned RD_LAT = DELAY_MEM_READ_LATENCY + 1;  // negedges from raise
   localparam int unsigned WR_LAT = 1;
   localparam int unsigned WR_OCCUPY = 2;                        // cycles a write holds the port

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic clear_busy;

   always #5 clk = ~clk;

   delay_mem_responder_if #(.data_width(DW), .addr_width(AW)) bus ();

   delay_mem_responder #(
      .data_width  (DW),
      .memory_size (MS)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .clear_busy (clear_busy)
   );

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mdata  [MS];
   bit            mknown [MS];
   logic [DW-1:0] last_rd;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit oob(input logic [AW-1:0] a);
      return a >= AW'(MS);
   endfunction

   function automatic bit readable(input logic [AW-1:0] a);
      if (oob(a)) return 1'b1;
      return mknown[a];
   endfunction

   function automatic logic [DW-1:0] expect_rd(input logic [AW-1:0] a);
      if (oob(a)) return '0;
      return mdata[a];
   endfunction

   function automatic logic [AW-1:0] pick_addr();
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r < 14)      return AW'($urandom_range(0, 15));
      else if (r < 17) return AW'($urandom_range(MS - 4, MS - 1));
      else if (r < 19) return AW'($urandom_range(MS, MS + 3));
      else             return '1;
   endfunction

   task automatic check_outputs_zero(input string tag);
      check_val(tag, {bus.mem_write_ack, bus.mem_read_valid, bus.addr_error,
                      $unsigned(bus.mem_data_in)}, '0);
   endtask

   // Call right after reset_n rises on a negedge.
   task automatic finish_reset();
      int cnt = 0;
      bit spur = 1'b0;
`ifdef DELAY_MEM_CLEAR_EN
      while (clear_busy === 1'b1 && cnt < 3 * MS) begin
         cnt++;
         @(negedge clk);
         if (bus.mem_write_ack === 1'b1 || bus.mem_read_valid === 1'b1) spur = 1'b1;
      end
      check_val("clear_len", cnt, MS);
      for (int i = 0; i < MS; i++) begin
         mdata[i]  = '0;
         mknown[i] = 1'b1;
      end
`else
      check_val("clear_busy_off", {31'b0, clear_busy}, 0);
      repeat (4) begin
         @(negedge clk);
         if (bus.mem_write_ack === 1'b1 || bus.mem_read_valid === 1'b1) spur = 1'b1;
      end
`endif
      check_val("rst_quiet", {31'b0, spur}, 0);
      last_rd = '0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      bit got = 1'b0;
      bus.mem_write_addr = a;
      bus.mem_data_out   = d;
      bus.mem_write_req  = 1'b1;
      while (!got && n < 8) begin
         @(negedge clk);
         n++;
         if (bus.mem_write_ack === 1'b1) got = 1'b1;
      end
      check_val("wr_lat", n, WR_LAT);
      check_val("wr_err", {31'b0, bus.addr_error}, {31'b0, oob(a)});
      bus.mem_write_req = 1'b0;
      @(negedge clk);
      check_val("wr_pulse", {bus.mem_write_ack, bus.addr_error}, 0);
      check_val("rd_hold", $unsigned(bus.mem_data_in), last_rd);
      if (!oob(a)) begin
         mdata[a]  = d;
         mknown[a] = 1'b1;
      end
   endtask

   task automatic do_read(input logic [AW-1:0] a);
      int n = 0;
      bit got = 1'b0;
      bus.mem_read_addr = a;
      bus.mem_read_req  = 1'b1;
      while (!got && n < 10) begin
         @(negedge clk);
         n++;
         if (bus.mem_read_valid === 1'b1) got = 1'b1;
      end
      check_val("rd_lat", n, RD_LAT);
      check_val("rd_err", {31'b0, bus.addr_error}, {31'b0, oob(a)});
      check_val("rd_data", $unsigned(bus.mem_data_in), expect_rd(a));
      last_rd = expect_rd(a);
      bus.mem_read_req = 1'b0;
      @(negedge clk);
      check_val("rd_pulse", {bus.mem_read_valid, bus.addr_error}, 0);
   endtask

   // Both requests raised together: the write is served first, the read
   // afterwards and sees the written word.
   task automatic do_both(input logic [AW-1:0] wa, input logic [DW-1:0] d,
                          input logic [AW-1:0] ra);
      int n = 0, wn = 0, rn = 0;
      bus.mem_write_addr = wa;
      bus.mem_data_out   = d;
      bus.mem_read_addr  = ra;
      bus.mem_write_req  = 1'b1;
      bus.mem_read_req   = 1'b1;
      while ((wn == 0 || rn == 0) && n < 14) begin
         @(negedge clk);
         n++;
         if (wn == 0 && bus.mem_write_ack === 1'b1) begin
            wn = n;
            check_val("both_wr_err", {31'b0, bus.addr_error}, {31'b0, oob(wa)});
            if (!oob(wa)) begin
               mdata[wa]  = d;
               mknown[wa] = 1'b1;
            end
            bus.mem_write_req = 1'b0;
         end
         if (rn == 0 && bus.mem_read_valid === 1'b1) begin
            rn = n;
            check_val("both_rd_err", {31'b0, bus.addr_error}, {31'b0, oob(ra)});
            check_val("both_rd_data", $unsigned(bus.mem_data_in), expect_rd(ra));
            last_rd = expect_rd(ra);
            bus.mem_read_req = 1'b0;
         end
      end
      bus.mem_write_req = 1'b0;
      bus.mem_read_req  = 1'b0;
      check_val("both_wr_lat", wn, WR_LAT);
      check_val("both_rd_lat", rn, WR_OCCUPY + RD_LAT);
      @(negedge clk);
      check_val("both_quiet", {bus.mem_write_ack, bus.mem_read_valid}, 0);
   endtask

   initial begin
      logic [AW-1:0] a, b;
      logic [DW-1:0] d;
      logic [3:0]    acks;
      int unsigned   op;

      bus.mem_write_req  = 1'b0;
      bus.mem_write_addr = '0;
      bus.mem_data_out   = '0;
      bus.mem_read_req   = 1'b0;
      bus.mem_read_addr  = '0;
      for (int i = 0; i < MS; i++) begin
         mdata[i]  = '0;
         mknown[i] = 1'b0;
      end
      last_rd = '0;

      // Reset state
      repeat (3) @(negedge clk);
      check_outputs_zero("rst_outputs");
`ifdef DELAY_MEM_CLEAR_EN
      check_val("rst_clear_busy", {31'b0, clear_busy}, 1);
`else
      check_val("rst_clear_busy", {31'b0, clear_busy}, 0);
`endif
      reset_n = 1'b1;
      finish_reset();

      // Basic write then read
      do_write(AW'(5), 16'h1234);
      do_read(AW'(5));

      // Simultaneous requests to the same address
      do_both(AW'(10), 16'h7FFF, AW'(10));

      // Write request held for three cycles: two acks, guard cycle silent
      bus.mem_write_addr = AW'(3);
      bus.mem_data_out   = 16'h0333;
      bus.mem_write_req  = 1'b1;
      acks = '0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         acks = {acks[2:0], bus.mem_write_ack};
         if (k == 3) bus.mem_write_req = 1'b0;
      end
      check_val("held_wr_acks", {28'b0, acks}, 32'h0000_000A);
      mdata[3]  = 16'h0333;
      mknown[3] = 1'b1;
      do_read(AW'(3));

      // Range boundary
      do_write(AW'(MS - 1), 16'h0BEE);
      do_write(AW'(MS + 1), 16'h5555);
      do_write(AW'(MS), 16'h6666);
      do_read(AW'(MS + 1));
      do_read(AW'(MS));
      do_read(AW'(MS - 1));

      // Reset in the cycle after a read is accepted
      bus.mem_read_addr = AW'(5);
      bus.mem_read_req  = 1'b1;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("rst_mid_read");
      bus.mem_read_req = 1'b0;
      @(negedge clk);
      check_outputs_zero("rst_hold");
      reset_n = 1'b1;
      finish_reset();
      do_read(AW'(5));

      // Reset before a write reaches its commit edge drops the write
      do_write(AW'(7), 16'h1111);
      bus.mem_write_addr = AW'(7);
      bus.mem_data_out   = 16'h2222;
      bus.mem_write_req  = 1'b1;
      @(negedge clk);
      check_val("wdrop_ack", {31'b0, bus.mem_write_ack}, 1);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("rst_mid_write");
      bus.mem_write_req = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      finish_reset();
      do_read(AW'(7));

      // Write to address 0, reset, read back
      do_write(AW'(0), 16'hAAAA);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      finish_reset();
      do_read(AW'(0));

      // Randomised traffic
      for (int it = 0; it < 80; it++) begin
         a  = pick_addr();
         d  = DW'($urandom);
         op = $urandom_range(0, 2);
         if (op != 0 && !readable(a)) op = 0;
         case (op)
            0: do_write(a, d);
            1: do_read(a);
            default: begin
               b = pick_addr();
               if (!readable(b)) b = a;
               do_both(b, d, a);
            end
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
